// File: rtl/pea_result_fifo.sv
// rtl/pea_result_fifo.sv - synchronous result/status token FIFO with registered read data
// Optional sticky overflow/underflow flags: define PEA_FIFO_ERR_FLAG_EN
module pea_result_fifo #(
  parameter int word_size = 32,
  parameter int buffer_size = 1024,
  localparam int ptr_width = $clog2(buffer_size),
  localparam int cnt_width = ptr_width + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [word_size-1:0] din,
  input  logic                 rd_en,
  output logic [word_size-1:0] dout,
  output logic [cnt_width-1:0] population,
  output logic [cnt_width-1:0] free_space,
  output logic                 full,
  output logic                 empty
`ifdef PEA_FIFO_ERR_FLAG_EN
  ,
  output logic                 ovf,
  output logic                 udf
`endif
);

  logic [word_size-1:0] mem [buffer_size];
  logic [ptr_width-1:0] wr_ptr;
  logic [ptr_width-1:0] rd_ptr;
  logic [cnt_width-1:0] count;
  logic                 wr_acc;
  logic                 rd_acc;

  assign population = count;
  assign free_space = cnt_width'(buffer_size) - count;
  assign full       = (count == cnt_width'(buffer_size));
  assign empty      = (count == '0);

  // A write into a full buffer is only safe when a read frees a slot on the same edge.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ptr_width'(1);
      end
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ptr_width'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + cnt_width'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - cnt_width'(1);
      end
    end
  end

`ifdef PEA_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) begin
        ovf <= 1'b1;
      end
      if (rd_en && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pea_result_fifo.sv
// tb/tb_pea_result_fifo.sv - self-checking bench for pea_result_fifo (depth 4) with queue reference model
module tb_pea_result_fifo;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic [CW-1:0] population;
  logic [CW-1:0] free_space;
  logic          full;
  logic          empty;
`ifdef PEA_FIFO_ERR_FLAG_EN
  logic          ovf;
  logic          udf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  bit           m_ovf;
  bit           m_udf;

  always #5 clk = ~clk;

  pea_result_fifo #(.word_size(W), .buffer_size(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .population(population), .free_space(free_space), .full(full), .empty(empty)
`ifdef PEA_FIFO_ERR_FLAG_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  // Applies one clock of stimulus and advances the reference model by the same edge.
  task automatic cycle(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
    rst = r; wr_en = w; rd_en = rd; din = d;
    if (r) begin
      q.delete();
      m_dout = '0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      bit racc, wacc;
      racc = rd && (q.size() != 0);
      wacc = w && ((q.size() < D) || racc);
      if (w && !wacc) m_ovf = 1;
      if (rd && !racc) m_udf = 1;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    cycle(1, 1, 1, 32'hFFFF_FFFF);
    cycle(0, 0, 0, '0);
    checks++; if (population !== 3'd0) begin errors++; $display("FAIL reset_population: got %0d expected 0", population); end
    checks++; if (free_space !== 3'd4) begin errors++; $display("FAIL reset_free_space: got %0d expected 4", free_space); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
`ifdef PEA_FIFO_ERR_FLAG_EN
    checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {ovf, udf}); end
`endif
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h100 + i);
    checks++; if (population !== 3'd3) begin errors++; $display("FAIL pre_reset_population: got %0d expected 3", population); end
    cycle(1, 0, 0, '0);
    checks++; if (population !== 3'd0) begin errors++; $display("FAIL midstream_reset_population: got %0d expected 0", population); end
    checks++; if (empty !== 1'b1 || free_space !== 3'd4) begin errors++; $display("FAIL midstream_reset_status: got empty=%0b free=%0d expected empty=1 free=4", empty, free_space); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 4; i++) cycle(0, 1, 0, i);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", full); end
    checks++; if (free_space !== 3'd0) begin errors++; $display("FAIL fill_free_space: got %0d expected 0", free_space); end
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 1, '0);
      checks++; if (dout !== W'(i)) begin errors++; $display("FAIL drain_dout[%0d]: got %h expected %h", i, dout, W'(i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_overflow;
`ifdef PEA_FIFO_ERR_FLAG_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before: got %0b expected 0", ovf); end
`endif
    for (int i = 1; i <= 4; i++) cycle(0, 1, 0, i);
    cycle(0, 1, 0, 32'h0000_DEAD);
    checks++; if (population !== 3'd4) begin errors++; $display("FAIL ovf_population: got %0d expected 4", population); end
`ifdef PEA_FIFO_ERR_FLAG_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", ovf); end
`endif
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 1, '0);
      checks++; if (dout !== W'(i)) begin errors++; $display("FAIL ovf_readout[%0d]: got %h expected %h", i, dout, W'(i)); end
    end
  endtask

  task automatic test_underflow;
    cycle(0, 0, 1, '0);
    cycle(0, 0, 1, '0);
    checks++; if (dout !== 32'h4) begin errors++; $display("FAIL udf_dout_hold: got %h expected 4", dout); end
    checks++; if (population !== 3'd0) begin errors++; $display("FAIL udf_population: got %0d expected 0", population); end
`ifdef PEA_FIFO_ERR_FLAG_EN
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_flag: got %0b expected 1", udf); end
`endif
    cycle(0, 1, 1, 32'h1234_5678);
    checks++; if (population !== 3'd1) begin errors++; $display("FAIL empty_rw_population: got %0d expected 1", population); end
    checks++; if (dout !== 32'h4) begin errors++; $display("FAIL empty_rw_dout: got %h expected 4", dout); end
    cycle(0, 0, 1, '0);
    checks++; if (dout !== 32'h1234_5678) begin errors++; $display("FAIL empty_rw_readback: got %h expected 12345678", dout); end
  endtask

  task automatic test_full_rw;
    for (int i = 1; i <= 4; i++) cycle(0, 1, 0, i);
    cycle(0, 1, 1, 32'h5);
    checks++; if (dout !== 32'h1) begin errors++; $display("FAIL full_rw_dout: got %h expected 1", dout); end
    checks++; if (population !== 3'd4) begin errors++; $display("FAIL full_rw_population: got %0d expected 4", population); end
    for (int i = 2; i <= 5; i++) begin
      cycle(0, 0, 1, '0);
      checks++; if (dout !== W'(i)) begin errors++; $display("FAIL full_rw_readout[%0d]: got %h expected %h", i, dout, W'(i)); end
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 32'hA0 + i);
      cycle(0, 0, 1, '0);
      checks++; if (dout !== W'(32'hA0 + i)) begin errors++; $display("FAIL wrap_dout[%0d]: got %h expected %h", i, dout, W'(32'hA0 + i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_random;
    cycle(1, 0, 0, '0);
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(99) < 55), ($urandom_range(99) < 45), $urandom);
      checks++; if (dout !== m_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", n, dout, m_dout); end
      checks++; if (population !== CW'(q.size())) begin errors++; $display("FAIL rand_population[%0d]: got %0d expected %0d", n, population, q.size()); end
      checks++; if (free_space !== CW'(D - q.size())) begin errors++; $display("FAIL rand_free_space[%0d]: got %0d expected %0d", n, free_space, D - q.size()); end
      checks++; if ({full, empty} !== {q.size() == D, q.size() == 0}) begin errors++; $display("FAIL rand_full_empty[%0d]: got %b expected %b", n, {full, empty}, {q.size() == D, q.size() == 0}); end
`ifdef PEA_FIFO_ERR_FLAG_EN
      checks++; if ({ovf, udf} !== {m_ovf, m_udf}) begin errors++; $display("FAIL rand_flags[%0d]: got %b expected %b", n, {ovf, udf}, {m_ovf, m_udf}); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    m_dout = '0; m_ovf = 0; m_udf = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pea_result_fifo.md
Name: pea_result_fifo

Overview:
- Synchronous output FIFO directly downstream of the PEA top-level firing logic.
- Two instances are used: one buffers 32-bit result tokens, the other buffers 32-bit status tokens.
- Accepts tokens on the producer's wr_en/data strobe.
- Reports free_space back to the producer, which uses it for its firing enable decision.
- Exposes population and rd_en/dout to the testbench or host consumer.

Parameters:
- word_size, 32: token width in bits; 2x the 16-bit PEA command/data word.
- buffer_size, 1024: depth in words; must be a power of two, at least 2.
- cnt_width, log2(buffer_size)+1: width of the population and free_space counts, so that 0..buffer_size are representable. Derived; do not override.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- wr_en, input, 1: write strobe from the producer (result_wr_en or status_wr_en).
- din, input, word_size: token to write (result_out or status_out).
- rd_en, input, 1: read strobe from the consumer.
- dout, output, word_size: registered read data.
- population, output, cnt_width: number of stored words.
- free_space, output, cnt_width: buffer_size minus population.
- full, output, 1: high when population == buffer_size.
- empty, output, 1: high when population == 0.

Behaviour:
- Storage: buffer_size x word_size register/RAM array. wr_ptr and rd_ptr are log2(buffer_size) bits and wrap naturally from buffer_size-1 to 0. A separate count register of cnt_width bits tracks occupancy.
- Reset (rst=1 at a posedge):
  - wr_ptr=0, rd_ptr=0, count=0, dout=0.
  - Outputs: population=0, free_space=buffer_size, full=0, empty=1.
  - Array contents are don't-care.
  - Reset overrides wr_en/rd_en in the same cycle.
  - Reset mid-stream discards all stored tokens.
- Write accept: wr_acc = wr_en && (!full || rd_en). A write while full is accepted only if a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en && !empty.
- On wr_acc: mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1.
- On rd_acc: dout <= mem[rd_ptr]; rd_ptr <= rd_ptr+1.
  - Read latency is 1 cycle: data appears on dout after the posedge that samples rd_en.
  - dout holds its last value when no read is accepted.
- Count update:
  - +1 if wr_acc && !rd_acc.
  - -1 if rd_acc && !wr_acc.
  - Unchanged otherwise.
- Simultaneous events:
  - Empty with wr_en && rd_en: write accepted, read ignored (no bypass). count becomes 1; dout unchanged.
  - Full with wr_en && rd_en: both accepted. Oldest word goes to dout, new word is stored, count stays buffer_size.
  - Mid-range with both: both accepted, count unchanged.
- Overflow: wr_en while full without rd_en drops the write. Pointers, count and memory are unchanged.
- Underflow: rd_en while empty is ignored. dout, pointers and count are unchanged.
- Status outputs: population, free_space, full and empty are combinational from the count register. They update in the cycle after the accepting edge; there is no lookahead.
- Ordering: strict FIFO order, no reordering or duplication.

Optional Feature:
- Macro: PEA_FIFO_ERR_FLAG_EN.
- When defined, adds two outputs:
  - ovf (1 bit): sticky; set on the cycle after a dropped write (wr_en && full && !rd_en).
  - udf (1 bit): sticky; set on the cycle after an ignored read (rd_en && empty).
  - Both are cleared only by rst, and reset to 0.
- When undefined: the ports do not exist, no flag logic is built, and drop/ignore behaviour is identical.

Test Plan:
- Reset, then idle. Required: population=0, free_space=buffer_size, empty=1, full=0, dout=0. Then assert rst for 1 cycle after 3 writes; population returns to 0.
- (buffer_size=4) Write 0x00000001..0x00000004 on 4 consecutive cycles. Required: full=1, free_space=0. Then read 4 cycles; dout sequence is 1,2,3,4, one cycle after each rd_en, and empty=1 afterward.
- (buffer_size=4) While full, wr_en with din=0x0000DEAD and no rd_en. Required: population stays 4, read-out sequence unchanged, ovf=1 if PEA_FIFO_ERR_FLAG_EN.
- Empty FIFO, rd_en for 2 cycles. Required: dout holds its previous value, population=0, udf=1 if the flag is enabled. Then wr_en && rd_en on the same cycle with din=0x12345678. Required: population=1, dout unchanged.
- Full FIFO holding 1..4, wr_en && rd_en with din=5. Required: dout=1, population=4. Subsequent reads return 2,3,4,5.
- Wrap-around: 10 interleaved write/read pairs on a size-4 FIFO with distinct values 0xA0..0xA9. Required: all read back in order, no loss across pointer wrap.
